// File: rtl/csr_trap_unit.sv
// ============================================================================
//  Module      : csr_trap_unit
//  Description : Machine-mode CSR file and trap sequencer for the single-issue
//                RV32I core. Executes CSRRW/CSRRS/CSRRC (register and
//                immediate forms), detects illegal CSR accesses, and
//                prioritises interrupts and exceptions into a single trap
//                decision. On a trap it updates mepc/mcause/mstatus. On MRET
//                it restores mstatus. It owns mcycle/minstret and, optionally,
//                the machine timer.
//
//  Optional    : `define CSR_TIMER_EN adds the mtime/mtimecmp timer. These
//                CSRs are at 0x7C0-0x7C3 and drive mip.MTIP. The
//                TIMER_PRESCALE parameter exists only with this macro.
//
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                instr_valid        - instruction in execute this cycle
//                inst_pc            - PC of that instruction
//                csr_op/csr_source  - CSR operation and operand select
//                csr_addr           - CSR address
//                rs1_idx/rs1_data   - rs1 field (zimm) and register operand
//                exc_request/cause  - ECALL/EBREAK request and its cause
//                inst_invalid       - decoder illegal instruction
//                exc_ret            - MRET
//                ext_irq            - level external interrupt
//                csr_rdata          - pre-write CSR value for rd
//                exception_present  - trap taken this cycle
//                mtvec_out/mepc_out - PC redirect targets
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0010,
    parameter logic [31:0] MHARTID     = 32'd0
`ifdef CSR_TIMER_EN
    ,
    parameter int unsigned TIMER_PRESCALE = 1
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] inst_pc,
    input  logic [1:0]  csr_op,
    input  logic        csr_source,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_data,
    input  logic        exc_request,
    input  logic [31:0] exc_cause,
    input  logic        inst_invalid,
    input  logic        exc_ret,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        exception_present,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MISA      = 12'h301;
    localparam logic [11:0] c_MIE       = 12'h304;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MIP       = 12'h344;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;
    localparam logic [11:0] c_MTIME     = 12'h7C0;
    localparam logic [11:0] c_MTIMEH    = 12'h7C1;
    localparam logic [11:0] c_MTIMECMP  = 12'h7C2;
    localparam logic [11:0] c_MTIMECMPH = 12'h7C3;

    localparam logic [31:0] c_MISA_VAL  = 32'h4000_0100;
    localparam logic [31:0] c_ALIGN4    = 32'hFFFF_FFFC;
    localparam logic [31:0] c_CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] c_CAUSE_TMR = 32'h8000_0007;
    localparam logic [31:0] c_CAUSE_ILL = 32'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [31:0] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic [63:0] mcycle_q,       mcycle_d;
    logic [63:0] minstret_q,     minstret_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [31:0] w_src;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [31:0] w_cause;
    logic        w_mapped;
    logic        w_read_only;
    logic        w_wr_attempt;
    logic        w_illegal;
    logic        w_irq_ext;
    logic        w_irq_tmr;
    logic        w_trap;
    logic        w_do_write;
    logic        w_retire;
    logic        w_mret;
    logic        w_mtip;

`ifdef CSR_TIMER_EN
    localparam int unsigned c_PS_W    = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TIMER_PRESCALE - 1);

    logic [63:0]       mtime_q,    mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic [c_PS_W-1:0] prescale_q, prescale_d;

    assign w_mtip = (mtime_q >= mtimecmp_q);
`else
    assign w_mtip = 1'b0;
`endif

    assign w_src = csr_source ? {27'd0, rs1_idx} : rs1_data;

    // Read mux: also flags unmapped addresses and the read-only registers
    // that live outside the 0xC00-0xFFF read-only address block.
    always_comb begin
        w_old       = 32'd0;
        w_mapped    = 1'b1;
        w_read_only = 1'b0;
        case (csr_addr)
            c_MSTATUS:   w_old = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            c_MISA: begin
                w_old       = c_MISA_VAL;
                w_read_only = 1'b1;
            end
            c_MIE:       w_old = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
            c_MTVEC:     w_old = mtvec_q;
            c_MSCRATCH:  w_old = mscratch_q;
            c_MEPC:      w_old = mepc_q;
            c_MCAUSE:    w_old = mcause_q;
            c_MIP: begin
                w_old       = {20'd0, ext_irq, 3'd0, w_mtip, 7'd0};
                w_read_only = 1'b1;
            end
            c_MCYCLE:    w_old = mcycle_q[31:0];
            c_MCYCLEH:   w_old = mcycle_q[63:32];
            c_MINSTRET:  w_old = minstret_q[31:0];
            c_MINSTRETH: w_old = minstret_q[63:32];
            c_MHARTID:   w_old = MHARTID;
`ifdef CSR_TIMER_EN
            c_MTIME:     w_old = mtime_q[31:0];
            c_MTIMEH:    w_old = mtime_q[63:32];
            c_MTIMECMP:  w_old = mtimecmp_q[31:0];
            c_MTIMECMPH: w_old = mtimecmp_q[63:32];
`endif
            default:     w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'd1:    w_new = w_src;
            2'd2:    w_new = w_old | w_src;
            2'd3:    w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // Set/clear with rs1 (or zimm) field zero are pure reads.
    assign w_wr_attempt = (csr_op == 2'd1) || ((csr_op != 2'd0) && (rs1_idx != 5'd0));

    assign w_illegal = instr_valid && (csr_op != 2'd0) &&
                       (!w_mapped ||
                        (w_wr_attempt && (w_read_only || (csr_addr[11:10] == 2'b11))));

    assign w_irq_ext = mstatus_mie_q & mie_meie_q & ext_irq;
    assign w_irq_tmr = mstatus_mie_q & mie_mtie_q & w_mtip;

    assign w_trap = instr_valid &
                    (exc_request | inst_invalid | w_illegal | w_irq_ext | w_irq_tmr);

    always_comb begin
        if (w_irq_ext) begin
            w_cause = c_CAUSE_EXT;
        end else if (w_irq_tmr) begin
            w_cause = c_CAUSE_TMR;
        end else if (w_illegal || inst_invalid) begin
            w_cause = c_CAUSE_ILL;
        end else begin
            w_cause = exc_cause;
        end
    end

    // Illegal accesses always trap, so a non-trapping write is legal.
    assign w_do_write = instr_valid & ~w_trap & w_wr_attempt;
    assign w_retire   = instr_valid & ~w_trap;
    assign w_mret     = instr_valid & ~w_trap & exc_ret;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, w_retire};

        if (w_trap) begin
            mepc_d         = inst_pc & c_ALIGN4;
            mcause_d       = w_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (w_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        // A software write to a counter half replaces this cycle's increment.
        if (w_do_write) begin
            case (csr_addr)
                c_MSTATUS: begin
                    mstatus_mie_d  = w_new[3];
                    mstatus_mpie_d = w_new[7];
                end
                c_MIE: begin
                    mie_meie_d = w_new[11];
                    mie_mtie_d = w_new[7];
                end
                c_MTVEC:     mtvec_d    = w_new & c_ALIGN4;
                c_MSCRATCH:  mscratch_d = w_new;
                c_MEPC:      mepc_d     = w_new & c_ALIGN4;
                c_MCAUSE:    mcause_d   = w_new;
                c_MCYCLE:    mcycle_d   = {mcycle_q[63:32], w_new};
                c_MCYCLEH:   mcycle_d   = {w_new, mcycle_q[31:0]};
                c_MINSTRET:  minstret_d = {minstret_q[63:32], w_new};
                c_MINSTRETH: minstret_d = {w_new, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & c_ALIGN4;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

`ifdef CSR_TIMER_EN
    // ------------------------------------------------------------------
    // Machine timer: mtime advances once every TIMER_PRESCALE clocks.
    // ------------------------------------------------------------------
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        prescale_d = prescale_q + c_PS_W'(1);
        if (prescale_q == c_PS_LAST) begin
            prescale_d = '0;
            mtime_d    = mtime_q + 64'd1;
        end
        if (w_do_write) begin
            case (csr_addr)
                c_MTIME:     mtime_d    = {mtime_q[63:32], w_new};
                c_MTIMEH:    mtime_d    = {w_new, mtime_q[31:0]};
                c_MTIMECMP:  mtimecmp_d = {mtimecmp_q[63:32], w_new};
                c_MTIMECMPH: mtimecmp_d = {w_new, mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= {64{1'b1}};
            prescale_q <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            prescale_q <= prescale_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign csr_rdata         = (rst || (csr_op == 2'd0)) ? 32'd0 : w_old;
    assign exception_present = w_trap & ~rst;
    assign mtvec_out         = mtvec_q;
    assign mepc_out          = mepc_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
// ============================================================================
//  Module      : tb_csr_trap_unit
//  Description : Directed self-checking bench for csr_trap_unit. Inputs change
//                on the falling clock edge. Combinational outputs are sampled
//                1 time unit later, and registered state is observed after the
//                next rising edge. With CSR_TIMER_EN it also exercises the
//                machine timer. Without it, it checks that the timer addresses
//                trap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_trap_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] inst_pc;
    logic [1:0]  csr_op;
    logic        csr_source;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        exc_request;
    logic [31:0] exc_cause;
    logic        inst_invalid;
    logic        exc_ret;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        exception_present;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;

    int n_checks = 0;
    int n_fail   = 0;

    csr_trap_unit u_dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .inst_pc           (inst_pc),
        .csr_op            (csr_op),
        .csr_source        (csr_source),
        .csr_addr          (csr_addr),
        .rs1_idx           (rs1_idx),
        .rs1_data          (rs1_data),
        .exc_request       (exc_request),
        .exc_cause         (exc_cause),
        .inst_invalid      (inst_invalid),
        .exc_ret           (exc_ret),
        .ext_irq           (ext_irq),
        .csr_rdata         (csr_rdata),
        .exception_present (exception_present),
        .mtvec_out         (mtvec_out),
        .mepc_out          (mepc_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_valid  = 1'b0;
        inst_pc      = 32'd0;
        csr_op       = 2'd0;
        csr_source   = 1'b0;
        csr_addr     = 12'd0;
        rs1_idx      = 5'd0;
        rs1_data     = 32'd0;
        exc_request  = 1'b0;
        exc_cause    = 32'd0;
        inst_invalid = 1'b0;
        exc_ret      = 1'b0;
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic csr_instr(input logic [1:0] op, input logic src, input logic [11:0] addr,
                             input logic [4:0] idx, input logic [31:0] data, input logic [31:0] pc);
        instr_valid = 1'b1;
        inst_pc     = pc;
        csr_op      = op;
        csr_source  = src;
        csr_addr    = addr;
        rs1_idx     = idx;
        rs1_data    = data;
        #1;
    endtask

    task automatic plain_instr(input logic [31:0] pc);
        instr_valid = 1'b1;
        inst_pc     = pc;
        #1;
    endtask

    // Side-effect-free read: CSRRS x0 with instr_valid low.
    task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        instr_valid = 1'b0;
        csr_op      = 2'd2;
        csr_addr    = addr;
        rs1_idx     = 5'd0;
        #1;
        check_eq(tag, csr_rdata, exp);
        idle_inputs();
    endtask

    initial begin
        rst     = 1'b1;
        ext_irq = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_mtvec_out", mtvec_out, 32'h0000_0010);
        check_eq("rst_mepc_out", mepc_out, 32'd0);
        check_eq("rst_exc", {31'd0, exception_present}, 32'd0);
        check_eq("rst_rdata", csr_rdata, 32'd0);
        rst = 1'b0;
        check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
        check_csr("rst_mcycle", 12'hB00, 32'd0);
        check_csr("misa", 12'h301, 32'h4000_0100);
        check_csr("mhartid", 12'hF14, 32'd0);
        check_csr("rst_mie", 12'h304, 32'd0);
        step(); step(); step();
        check_csr("mcycle_3", 12'hB00, 32'd3);
        check_csr("minstret_idle", 12'hB02, 32'd0);

        // CSRRW mtvec: low bits forced to zero, old value on rdata.
        csr_instr(2'd1, 1'b0, 12'h305, 5'd1, 32'h0000_0103, 32'h100);
        check_eq("mtvec_wr_rdata", csr_rdata, 32'h0000_0010);
        check_eq("mtvec_wr_exc", {31'd0, exception_present}, 32'd0);
        step();
        check_eq("mtvec_out", mtvec_out, 32'h0000_0100);

        // CSRRSI mstatus, 8: set MIE.
        csr_instr(2'd2, 1'b1, 12'h300, 5'd8, 32'd0, 32'h104);
        check_eq("mstatus_set_rdata", csr_rdata, 32'h0000_1800);
        step();
        check_csr("mstatus_mie1", 12'h300, 32'h0000_1808);

        // ECALL at 0x200.
        plain_instr(32'h200);
        exc_request = 1'b1;
        exc_cause   = 32'd11;
        #1;
        check_eq("ecall_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_eq("ecall_mepc", mepc_out, 32'h200);
        check_csr("ecall_mcause", 12'h342, 32'd11);
        check_csr("ecall_mstatus", 12'h300, 32'h0000_1880);
        check_csr("ecall_minstret", 12'hB02, 32'd2);

        // MRET.
        plain_instr(32'h204);
        exc_ret = 1'b1;
        #1;
        check_eq("mret_exc", {31'd0, exception_present}, 32'd0);
        step();
        check_csr("mret_mstatus", 12'h300, 32'h0000_1888);
        check_eq("mret_mepc", mepc_out, 32'h200);

        // CSRRS mie with rs1 = x0: no write even though rs1_data is all ones.
        csr_instr(2'd2, 1'b0, 12'h304, 5'd0, 32'hFFFF_FFFF, 32'h208);
        check_eq("mie_rd_exc", {31'd0, exception_present}, 32'd0);
        step();
        check_csr("mie_unchanged", 12'h304, 32'd0);

        // CSRRW misa: read-only, traps with cause 2.
        csr_instr(2'd1, 1'b0, 12'h301, 5'd1, 32'd0, 32'h20C);
        check_eq("misa_wr_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_csr("misa_wr_mcause", 12'h342, 32'd2);
        check_csr("misa_after", 12'h301, 32'h4000_0100);
        check_eq("misa_wr_mepc", mepc_out, 32'h20C);
        check_csr("misa_minstret", 12'hB02, 32'd4);
        check_csr("misa_mstatus", 12'h300, 32'h0000_1880);

        // mhartid: read legal, write illegal.
        csr_instr(2'd2, 1'b0, 12'hF14, 5'd0, 32'd0, 32'h210);
        check_eq("mhartid_rd_exc", {31'd0, exception_present}, 32'd0);
        step();
        csr_instr(2'd1, 1'b0, 12'hF14, 5'd2, 32'd5, 32'h214);
        check_eq("mhartid_wr_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_eq("mhartid_wr_mepc", mepc_out, 32'h214);

        // Unmapped address, even as a pure read.
        csr_instr(2'd2, 1'b0, 12'h123, 5'd0, 32'd0, 32'h218);
        check_eq("unmapped_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_eq("unmapped_mepc", mepc_out, 32'h218);

        // mscratch write, clear, and clear with rs1 = x0.
        csr_instr(2'd1, 1'b0, 12'h340, 5'd1, 32'hF0F0_F0F0, 32'h21C);
        step();
        csr_instr(2'd3, 1'b0, 12'h340, 5'd3, 32'h00F0_00F0, 32'h220);
        check_eq("mscratch_clr_rdata", csr_rdata, 32'hF0F0_F0F0);
        step();
        check_csr("mscratch_clr", 12'h340, 32'hF000_F000);
        csr_instr(2'd3, 1'b0, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'h224);
        step();
        check_csr("mscratch_clr_x0", 12'h340, 32'hF000_F000);

        // mepc write aligns to 4.
        csr_instr(2'd1, 1'b0, 12'h341, 5'd1, 32'h0000_1237, 32'h228);
        step();
        check_eq("mepc_wr", mepc_out, 32'h0000_1234);

        // mcycle: write wins, then wraps from all-ones to zero.
        csr_instr(2'd1, 1'b0, 12'hB80, 5'd1, 32'hFFFF_FFFF, 32'h22C);
        step();
        csr_instr(2'd1, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'h230);
        step();
        check_csr("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        check_csr("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
        step();
        check_csr("mcycle_lo_wrap", 12'hB00, 32'd0);
        check_csr("mcycle_hi_wrap", 12'hB80, 32'd0);

        // minstret: the writing instruction does not also count itself.
        csr_instr(2'd1, 1'b0, 12'hB02, 5'd1, 32'd100, 32'h234);
        step();
        check_csr("minstret_wr", 12'hB02, 32'd100);
        plain_instr(32'h238);
        step();
        check_csr("minstret_inc", 12'hB02, 32'd101);

        // Illegal instruction outranks ECALL.
        plain_instr(32'h23C);
        inst_invalid = 1'b1;
        exc_request  = 1'b1;
        exc_cause    = 32'd11;
        #1;
        step();
        check_csr("prio_ill_mcause", 12'h342, 32'd2);

        // External interrupt.
        csr_instr(2'd2, 1'b1, 12'h300, 5'd8, 32'd0, 32'h300);
        step();
        csr_instr(2'd2, 1'b0, 12'h304, 5'd5, 32'h0000_0800, 32'h304);
        step();
        check_csr("mie_meie", 12'h304, 32'h0000_0800);
        ext_irq = 1'b1;
        #1;
        check_eq("irq_novalid_exc", {31'd0, exception_present}, 32'd0);
        check_csr("mip_meip", 12'h344, 32'h0000_0800);
        plain_instr(32'h400);
        inst_invalid = 1'b1;
        #1;
        check_eq("irq_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_csr("irq_mcause", 12'h342, 32'h8000_000B);
        check_eq("irq_mepc", mepc_out, 32'h400);
        plain_instr(32'h404);
        check_eq("irq_masked_exc", {31'd0, exception_present}, 32'd0);
        step();
        ext_irq = 1'b0;

`ifdef CSR_TIMER_EN
        // Timer: mtimecmp = 5, MTIE = 1, then restart mtime at 0.
        csr_instr(2'd1, 1'b0, 12'h7C2, 5'd1, 32'd5, 32'h500);
        step();
        csr_instr(2'd1, 1'b0, 12'h7C3, 5'd1, 32'd0, 32'h504);
        step();
        csr_instr(2'd2, 1'b0, 12'h304, 5'd1, 32'h0000_0080, 32'h508);
        step();
        csr_instr(2'd1, 1'b0, 12'h7C0, 5'd1, 32'd0, 32'h50C);
        step();
        csr_instr(2'd2, 1'b1, 12'h300, 5'd8, 32'd0, 32'h510);
        step();
        step(); step(); step();
        check_csr("tmr_mtime4", 12'h7C0, 32'd4);
        check_csr("tmr_mip_lo", 12'h344, 32'd0);
        plain_instr(32'h514);
        check_eq("tmr_early_exc", {31'd0, exception_present}, 32'd0);
        step();
        check_csr("tmr_mtime5", 12'h7C0, 32'd5);
        check_csr("tmr_mip_hi", 12'h344, 32'h0000_0080);
        plain_instr(32'h600);
        check_eq("tmr_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_csr("tmr_mcause", 12'h342, 32'h8000_0007);
        check_eq("tmr_mepc", mepc_out, 32'h600);
`else
        // Without the timer, its addresses are unmapped and MTIP reads 0.
        csr_instr(2'd2, 1'b0, 12'h7C0, 5'd0, 32'd0, 32'h500);
        check_eq("notmr_exc", {31'd0, exception_present}, 32'd1);
        step();
        check_eq("notmr_mepc", mepc_out, 32'h500);
        check_csr("notmr_mip", 12'h344, 32'd0);
`endif

        // Reset overrides a same-cycle trap.
        rst = 1'b1;
        plain_instr(32'h999);
        exc_request = 1'b1;
        exc_cause   = 32'd3;
        #1;
        check_eq("rst_trap_exc", {31'd0, exception_present}, 32'd0);
        step();
        check_eq("rst_trap_mepc", mepc_out, 32'd0);
        check_eq("rst_trap_mtvec", mtvec_out, 32'h0000_0010);
        rst = 1'b0;
        check_csr("rst_trap_mcause", 12'h342, 32'd0);
        check_csr("rst_trap_mstatus", 12'h300, 32'h0000_1800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
